// File: rtl/cvxif_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_result_buffer_if
// Description : Signal bundle between the coprocessor core / CPU result port
//               and the result buffer. 'slave' is the buffer's view,
//               'master' is the view of whoever drives the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cvxif_result_buffer_if #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int HARTID_W = 1,
  parameter int ID_W     = 1
) ();

  // Reservation side
  logic                      issue_accept_i;
  logic                      slot_avail_o;

  // ALU result capture side
  logic                      alu_valid_i;
  logic [HARTID_W-1:0]       alu_hartid_i;
  logic [ID_W-1:0]           alu_id_i;
  logic [XLEN-1:0]           alu_data_i;
  logic [4:0]                alu_rd_i;
  logic                      alu_we_i;

  // CV-X-IF result side
  logic                      result_valid_o;
  logic                      result_ready_i;
  logic [HARTID_W-1:0]       result_hartid_o;
  logic [ID_W-1:0]           result_id_o;
  logic [XLEN-1:0]           result_data_o;
  logic [4:0]                result_rd_o;
  logic                      result_we_o;

  // Status
  logic [$clog2(DEPTH):0]    count_o;
  logic                      overflow_o;

  modport slave (
    input  issue_accept_i, alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i,
           alu_rd_i, alu_we_i, result_ready_i,
    output slot_avail_o, result_valid_o, result_hartid_o, result_id_o,
           result_data_o, result_rd_o, result_we_o, count_o, overflow_o
  );

  modport master (
    output issue_accept_i, alu_valid_i, alu_hartid_i, alu_id_i, alu_data_i,
           alu_rd_i, alu_we_i, result_ready_i,
    input  slot_avail_o, result_valid_o, result_hartid_o, result_id_o,
           result_data_o, result_rd_o, result_we_o, count_o, overflow_o
  );

endinterface
`default_nettype wire

// File: rtl/cvxif_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_result_buffer
// Description : In-order result FIFO for the CV-X-IF coprocessor. Decouples
//               the ALU from CPU back-pressure and keeps a reservation count
//               so an instruction is only accepted when its result has a slot.
// Revision    : 1.0 - initial release
// ============================================================================
module cvxif_result_buffer #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int HARTID_W = 1,
  parameter int ID_W     = 1
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  cvxif_result_buffer_if.slave  bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [HARTID_W-1:0] hartid;
    logic [ID_W-1:0]     id;
    logic [XLEN-1:0]     data;
    logic [4:0]          rd;
    logic                we;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   r_reserved;
  logic                 r_overflow;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  logic                 w_push_drop;
  logic                 w_rsv_full;
  logic                 w_rsv;
  logic                 w_rsv_drop;
  entry_t               w_head;
  entry_t               w_alu_entry;

  // A pop frees a slot in the same cycle, so a full buffer (or full
  // reservation count) still accepts a new entry when the head leaves.
  assign w_pop       = (r_count != '0) && bus.result_ready_i;
  assign w_full      = (r_count == c_CNT_W'(DEPTH));
  assign w_push      = bus.alu_valid_i && (!w_full || w_pop);
  assign w_push_drop = bus.alu_valid_i && w_full && !w_pop;
  assign w_rsv_full  = (r_reserved == c_CNT_W'(DEPTH));
  assign w_rsv       = bus.issue_accept_i && (!w_rsv_full || w_pop);
  assign w_rsv_drop  = bus.issue_accept_i && w_rsv_full && !w_pop;

  assign w_alu_entry = '{hartid: bus.alu_hartid_i, id: bus.alu_id_i,
                         data: bus.alu_data_i, rd: bus.alu_rd_i,
                         we: bus.alu_we_i};

  // Result storage: written at the write pointer, never cleared on pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= w_alu_entry;
    end
  end

  // Read/write pointers and stored-entry count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
    end
  end

  // Reservation counter: claimed at issue, released when the result leaves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reserved <= '0;
    end else if (w_rsv && !w_pop) begin
      r_reserved <= r_reserved + c_CNT_W'(1);
    end else if (!w_rsv && w_pop && (r_reserved != '0)) begin
      r_reserved <= r_reserved - c_CNT_W'(1);
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
    end else if (w_push_drop || w_rsv_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_head              = r_mem[r_rptr];
  assign bus.result_valid_o  = (r_count != '0);
  assign bus.result_hartid_o = w_head.hartid;
  assign bus.result_id_o     = w_head.id;
  assign bus.result_data_o   = w_head.data;
  assign bus.result_rd_o     = w_head.rd;
  assign bus.result_we_o     = w_head.we;
  assign bus.count_o         = r_count;
  assign bus.overflow_o      = r_overflow;
  assign bus.slot_avail_o    = (r_reserved < c_CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_cvxif_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cvxif_result_buffer
// Description : Self-checking bench for cvxif_result_buffer. Expected results
//               are queued when pushed and compared when handed to the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_result_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int HW    = 1;
  localparam int IW    = 4;

  typedef struct packed {
    logic [HW-1:0]   hartid;
    logic [IW-1:0]   id;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  cvxif_result_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .HARTID_W(HW), .ID_W(IW)) bus ();

  cvxif_result_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .HARTID_W(HW), .ID_W(IW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  function automatic exp_t mk(input int i);
    exp_t e;
    e.hartid = HW'(i & 1);
    e.id     = IW'(i);
    e.data   = 32'h5A00_0000 | XLEN'(i);
    e.rd     = 5'(i + 1);
    e.we     = ~i[0];
    return e;
  endfunction

  function automatic exp_t head();
    exp_t g;
    g = {bus.result_hartid_o, bus.result_id_o, bus.result_data_o,
         bus.result_rd_o, bus.result_we_o};
    return g;
  endfunction

  task automatic idle_inputs();
    bus.issue_accept_i = 1'b0;
    bus.alu_valid_i    = 1'b0;
    bus.alu_hartid_i   = '0;
    bus.alu_id_i       = '0;
    bus.alu_data_i     = '0;
    bus.alu_rd_i       = '0;
    bus.alu_we_i       = 1'b0;
    bus.result_ready_i = 1'b0;
  endtask

  // Advance one cycle; pulse inputs drop after the edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    bus.issue_accept_i = 1'b0;
    bus.alu_valid_i    = 1'b0;
  endtask

  task automatic drive_alu(input exp_t e, input bit keep);
    bus.alu_valid_i  = 1'b1;
    bus.alu_hartid_i = e.hartid;
    bus.alu_id_i     = e.id;
    bus.alu_data_i   = e.data;
    bus.alu_rd_i     = e.rd;
    bus.alu_we_i     = e.we;
    if (keep) sb.push_back(e);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    n_vec++; if (bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.result_valid_o); end
    n_vec++; if (bus.count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    n_vec++; if (bus.slot_avail_o !== 1'b1) begin n_err++; $display("FAIL reset_slot_avail: got %b want 1", bus.slot_avail_o); end
    n_vec++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_o); end
    n_vec++; if (head() !== exp_t'(0)) begin n_err++; $display("FAIL reset_fields: got %h want 0", head()); end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    exp_t e;
    exp_t x;
    bus.issue_accept_i = 1'b1;
    tick();
    e = '{hartid: 1'b0, id: 4'd3, data: 32'hDEAD_BEEF, rd: 5'd5, we: 1'b1};
    bus.result_ready_i = 1'b1;
    drive_alu(e, 1'b1);
    n_vec++; if (bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got valid %b want 0", bus.result_valid_o); end
    tick();
    n_vec++;
    if (bus.result_valid_o === 1'b1 && sb.size() != 0) begin
      x = sb.pop_front();
      if (head() !== x) begin n_err++; $display("FAIL single_result: got %h want %h", head(), x); end
    end else begin
      n_err++; $display("FAIL single_valid: got %b want 1", bus.result_valid_o);
    end
    tick();
    n_vec++; if (bus.result_valid_o !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got valid %b want 0", bus.result_valid_o); end
    n_vec++; if (bus.count_o !== 3'd0 || bus.slot_avail_o !== 1'b1) begin n_err++; $display("FAIL single_after: got count %0d avail %b want 0 1", bus.count_o, bus.slot_avail_o); end
    bus.result_ready_i = 1'b0;
  endtask

  task automatic test_fill();
    exp_t x;
    bus.result_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.issue_accept_i = 1'b1;
      tick();
      n_vec++; if (bus.slot_avail_o !== (k < 3)) begin n_err++; $display("FAIL fill_avail_%0d: got %b want %b", k, bus.slot_avail_o, (k < 3)); end
    end
    for (int k = 0; k < 4; k++) begin
      drive_alu(mk(k), 1'b1);
      tick();
      n_vec++; if (bus.result_valid_o !== 1'b1 || head() !== sb[0]) begin n_err++; $display("FAIL fill_head_%0d: got %h want %h", k, head(), sb[0]); end
    end
    n_vec++; if (bus.count_o !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", bus.count_o); end
    repeat (2) begin
      tick();
      n_vec++; if (head() !== sb[0]) begin n_err++; $display("FAIL fill_hold: got %h want %h", head(), sb[0]); end
    end
    bus.result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      x = sb.pop_front();
      n_vec++; if (bus.result_valid_o !== 1'b1 || head() !== x) begin n_err++; $display("FAIL fill_drain_%0d: got %h want %h", k, head(), x); end
      tick();
    end
    n_vec++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin n_err++; $display("FAIL fill_empty: got valid %b count %0d want 0 0", bus.result_valid_o, bus.count_o); end
    bus.result_ready_i = 1'b0;
  endtask

  task automatic test_full_pushpop();
    exp_t x;
    bus.result_ready_i = 1'b0;
    repeat (4) begin bus.issue_accept_i = 1'b1; tick(); end
    for (int k = 1; k <= 4; k++) begin drive_alu(mk(k), 1'b1); tick(); end
    n_vec++; if (bus.count_o !== 3'd4) begin n_err++; $display("FAIL fpp_count_pre: got %0d want 4", bus.count_o); end
    bus.result_ready_i = 1'b1;
    bus.issue_accept_i = 1'b1;
    drive_alu(mk(7), 1'b1);
    x = sb.pop_front();
    n_vec++; if (head() !== x) begin n_err++; $display("FAIL fpp_pop: got %h want %h", head(), x); end
    tick();
    n_vec++; if (bus.count_o !== 3'd4 || bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_state: got count %0d ovf %b want 4 0", bus.count_o, bus.overflow_o); end
    n_vec++; if (bus.slot_avail_o !== 1'b0) begin n_err++; $display("FAIL fpp_avail: got %b want 0", bus.slot_avail_o); end
    for (int k = 0; k < 4; k++) begin
      x = sb.pop_front();
      n_vec++; if (bus.result_valid_o !== 1'b1 || head() !== x) begin n_err++; $display("FAIL fpp_drain_%0d: got %h want %h", k, head(), x); end
      tick();
    end
    n_vec++; if (bus.result_valid_o !== 1'b0 || bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL fpp_end: got valid %b ovf %b want 0 0", bus.result_valid_o, bus.overflow_o); end
    bus.result_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t x;
    int   sent = 0;
    int   max_cnt = 0;
    for (int cyc = 0; cyc < 80 && (sent < 10 || sb.size() > 0); cyc++) begin
      bus.result_ready_i = ((cyc % 2) == 0);
      if (sent < 10 && bus.slot_avail_o === 1'b1) begin
        bus.issue_accept_i = 1'b1;
        drive_alu(mk(sent), 1'b1);
        sent++;
      end
      if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
      if (bus.result_valid_o === 1'b1 && bus.result_ready_i === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL wrap_extra: got %h want nothing", head());
        end else begin
          x = sb.pop_front();
          if (head() !== x) begin n_err++; $display("FAIL wrap_order: got %h want %h", head(), x); end
        end
      end
      tick();
    end
    n_vec++; if (sent != 10 || sb.size() != 0) begin n_err++; $display("FAIL wrap_timeout: got sent %0d pending %0d want 10 0", sent, sb.size()); end
    n_vec++; if (max_cnt > 4) begin n_err++; $display("FAIL wrap_max_count: got %0d want <=4", max_cnt); end
    bus.result_ready_i = 1'b0;
  endtask

  task automatic test_errors();
    exp_t x;
    bus.result_ready_i = 1'b0;
    repeat (4) begin bus.issue_accept_i = 1'b1; tick(); end
    n_vec++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL err_ovf_pre: got %b want 0", bus.overflow_o); end
    bus.issue_accept_i = 1'b1;
    tick();
    n_vec++; if (bus.overflow_o !== 1'b1 || bus.slot_avail_o !== 1'b0) begin n_err++; $display("FAIL err_rsv: got ovf %b avail %b want 1 0", bus.overflow_o, bus.slot_avail_o); end
    for (int k = 8; k < 12; k++) begin drive_alu(mk(k), 1'b1); tick(); end
    drive_alu(mk(12), 1'b0);
    tick();
    n_vec++; if (bus.count_o !== 3'd4 || bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL err_drop: got count %0d ovf %b want 4 1", bus.count_o, bus.overflow_o); end
    n_vec++; if (head() !== sb[0]) begin n_err++; $display("FAIL err_head: got %h want %h", head(), sb[0]); end
    bus.result_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      x = sb.pop_front();
      n_vec++; if (bus.result_valid_o !== 1'b1 || head() !== x) begin n_err++; $display("FAIL err_drain_%0d: got %h want %h", k, head(), x); end
      tick();
    end
    bus.result_ready_i = 1'b0;
    n_vec++; if (bus.result_valid_o !== 1'b0 || bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got valid %b ovf %b want 0 1", bus.result_valid_o, bus.overflow_o); end
    // The ignored reservation must not linger: exactly 4 new claims fill it.
    for (int k = 0; k < 4; k++) begin
      bus.issue_accept_i = 1'b1;
      tick();
      n_vec++; if (bus.slot_avail_o !== (k < 3)) begin n_err++; $display("FAIL err_rsv_exact_%0d: got %b want %b", k, bus.slot_avail_o, (k < 3)); end
    end
  endtask

  task automatic test_midreset();
    exp_t x;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    sb.delete();
    bus.result_ready_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.issue_accept_i = 1'b1;
      drive_alu(mk(k), 1'b1);
      tick();
    end
    n_vec++; if (bus.count_o !== 3'd3 || bus.result_valid_o !== 1'b1) begin n_err++; $display("FAIL mrst_pre: got count %0d valid %b want 3 1", bus.count_o, bus.result_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_vec++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin n_err++; $display("FAIL mrst_async: got valid %b count %0d want 0 0", bus.result_valid_o, bus.count_o); end
    n_vec++; if (bus.slot_avail_o !== 1'b1) begin n_err++; $display("FAIL mrst_avail: got %b want 1", bus.slot_avail_o); end
    sb.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.issue_accept_i = 1'b1;
    bus.result_ready_i = 1'b1;
    drive_alu(mk(5), 1'b1);
    tick();
    n_vec++;
    if (bus.result_valid_o === 1'b1 && sb.size() != 0) begin
      x = sb.pop_front();
      if (head() !== x) begin n_err++; $display("FAIL mrst_result: got %h want %h", head(), x); end
    end else begin
      n_err++; $display("FAIL mrst_valid: got %b want 1", bus.result_valid_o);
    end
    tick();
    n_vec++; if (bus.result_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin n_err++; $display("FAIL mrst_end: got valid %b count %0d want 0 0", bus.result_valid_o, bus.count_o); end
    bus.result_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pushpop();
    test_wrap();
    test_errors();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
